// File: rtl/shl_pkg.sv
// Shared definitions for the sequential left shifter: mode codes, FSM states
// and a small helper for the carry value loaded at operand capture.
// Combinational definitions only; no latency and no backpressure involved.
// Imported by shl_step and shift_left_seq.
package shl_pkg;

    // Shift modes as presented on the mode input.
    localparam logic [1:0] MODE_LSL = 2'b00;   // logical: zero fill, carry <- msb
    localparam logic [1:0] MODE_ROL = 2'b01;   // rotate: msb wraps into lsb
    localparam logic [1:0] MODE_RCL = 2'b10;   // rotate through carry flag
    localparam logic [1:0] MODE_ASL = 2'b11;   // arithmetic: as LSL plus sticky overflow

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shl_state_t;

    // Carry flag value at capture: only rotate-through-carry seeds it from cin.
    function automatic logic capture_carry(input logic [1:0] mode, input logic cin);
        return (mode == MODE_RCL) ? cin : 1'b0;
    endfunction

endpackage

// File: rtl/shl_step.sv
// One-bit left-shift step for all four modes, plus per-step overflow.
// Purely combinational (zero latency); no flow control.
// Ports: data/carry/mode in; data_next/carry_next/ovf_step out. WIDTH >= 2.
module shl_step
    import shl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             carry,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_next,
    output logic             carry_next,
    output logic             ovf_step
);

    logic msb;
    assign msb = data[WIDTH-1];

    always_comb begin
        data_next = {data[WIDTH-2:0], 1'b0};
        case (mode)
            MODE_ROL: data_next = {data[WIDTH-2:0], msb};
            MODE_RCL: data_next = {data[WIDTH-2:0], carry};
            default:  data_next = {data[WIDTH-2:0], 1'b0};
        endcase
    end

    // Every mode pushes the outgoing msb into the carry flag.
    assign carry_next = msb;

    // A sign change on this step means the arithmetic result no longer fits.
    assign ovf_step = (mode == MODE_ASL) && (data[WIDTH-1] ^ data[WIDTH-2]);

endmodule

// File: rtl/shift_left_seq.sv
// Sequential left shifter: one bit position per clock, four modes, carry/overflow flags.
// Latency: done pulses amt+1 cycles after start is presented (amt=0 -> 1 cycle).
// Backpressure: start is taken only in IDLE/DONE; start while busy is dropped.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request, sampled in IDLE or DONE (back-to-back accepted in DONE)
//   mode         00 logical, 01 rotate, 10 rotate-through-carry, 11 arithmetic
//   amt          shift amount, cin carry-in (mode 10), x operand
//   busy         high while shifting; done one-cycle completion pulse
//   f/cout/ovf   result and flag registers, valid at done, held until next capture
//   abort        (only when SHL_ABORT_EN is defined) cancels a shift in progress
//
// Build option: define SHL_ABORT_EN to add the abort input. Without it every
// accepted operation runs to completion.
module shift_left_seq
    import shl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
`ifdef SHL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf
);

    shl_state_t       state;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode_q;

`ifdef SHL_ABORT_EN
    // Capture-time snapshot so an abort can put the outputs back as they were
    // right after the operand was loaded (ovf is always 0 at capture).
    logic [WIDTH-1:0] x_q;
    logic             cout_q;
`endif

    logic [WIDTH-1:0] step_f;
    logic             step_c;
    logic             step_o;

    shl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data       (f),
        .carry      (cout),
        .mode       (mode_q),
        .data_next  (step_f),
        .carry_next (step_c),
        .ovf_step   (step_o)
    );

    // busy and done are registered alongside the state so they are glitch-free
    // and line up exactly with the SHIFT / DONE states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            f      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            mode_q <= MODE_LSL;
`ifdef SHL_ABORT_EN
            x_q    <= '0;
            cout_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        f      <= x;
                        mode_q <= mode;
                        count  <= amt;
                        cout   <= capture_carry(mode, cin);
                        ovf    <= 1'b0;
`ifdef SHL_ABORT_EN
                        x_q    <= x;
                        cout_q <= capture_carry(mode, cin);
`endif
                        if (amt != '0) begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            // Zero shift completes straight away with f=x.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_SHIFT: begin
`ifdef SHL_ABORT_EN
                    if (abort) begin
                        // Abort beats the final step: restore and leave silently.
                        f     <= x_q;
                        cout  <= cout_q;
                        ovf   <= 1'b0;
                        count <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else
`endif
                    begin
                        f     <= step_f;
                        cout  <= step_c;
                        ovf   <= ovf | step_o;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_left_seq.sv
module tb_shift_left_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amt;
    logic       cin;
    logic [7:0] x;
`ifdef SHL_ABORT_EN
    logic       abort;
`endif
    logic       busy;
    logic       done;
    logic [7:0] f;
    logic       cout;
    logic       ovf;

    int passes = 0;
    int total  = 0;
    int lat;
    int bcy;

    shift_left_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .cin   (cin),
        .x     (x),
`ifdef SHL_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one request for a cycle, then wait (bounded) for done.
    // lat counts edges from start presentation to done; bcy counts busy cycles.
    task automatic do_op(input logic [7:0] xv, input logic [1:0] mv, input logic [2:0] av,
                         input logic cv, output int lt, output int bc);
        @(negedge clk);
        x = xv; mode = mv; amt = av; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lt = 1;
        bc = 0;
        while (!done && lt < 20) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lt++;
        end
    endtask

    initial begin
        start = 1'b0; mode = 2'b00; amt = 3'd0; cin = 1'b0; x = 8'h00;
`ifdef SHL_ABORT_EN
        abort = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_f",    32'(f),    32'h00);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_ovf",  32'(ovf),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Logical, amt=1.
        do_op(8'b10110101, 2'b00, 3'd1, 1'b0, lat, bcy);
        check("lsl_lat",  32'(lat),  32'd2);
        check("lsl_f",    32'(f),    32'b01101010);
        check("lsl_cout", 32'(cout), 32'h1);
        check("lsl_ovf",  32'(ovf),  32'h0);
        @(posedge clk); #1;
        check("lsl_done_pulse", 32'(done), 32'h0);
        check("lsl_hold_f",     32'(f),    32'b01101010);

        // Rotate, amt=3.
        do_op(8'b10110101, 2'b01, 3'd3, 1'b0, lat, bcy);
        check("rol_lat",  32'(lat),  32'd4);
        check("rol_busy", 32'(bcy),  32'd3);
        check("rol_f",    32'(f),    32'b10101101);
        check("rol_cout", 32'(cout), 32'h1);

        // Rotate through carry, amt=2, cin=1.
        do_op(8'b10110101, 2'b10, 3'd2, 1'b1, lat, bcy);
        check("rcl_f",    32'(f),    32'b11010111);
        check("rcl_cout", 32'(cout), 32'h0);
        check("rcl_ovf",  32'(ovf),  32'h0);

        // Arithmetic: sign change sets ovf, no sign change does not.
        do_op(8'b01000000, 2'b11, 3'd1, 1'b0, lat, bcy);
        check("asl1_f",    32'(f),    32'b10000000);
        check("asl1_cout", 32'(cout), 32'h0);
        check("asl1_ovf",  32'(ovf),  32'h1);
        do_op(8'b11000000, 2'b11, 3'd1, 1'b0, lat, bcy);
        check("asl2_f",    32'(f),    32'b10000000);
        check("asl2_cout", 32'(cout), 32'h1);
        check("asl2_ovf",  32'(ovf),  32'h0);

        // amt=0 in RCL: immediate done, f=x, cout=cin.
        do_op(8'b10110101, 2'b10, 3'd0, 1'b1, lat, bcy);
        check("z_lat",  32'(lat),  32'd1);
        check("z_busy", 32'(bcy),  32'd0);
        check("z_f",    32'(f),    32'b10110101);
        check("z_cout", 32'(cout), 32'h1);
        // Back-to-back: new start presented during the DONE cycle.
        do_op(8'h81, 2'b00, 3'd1, 1'b0, lat, bcy);
        check("b2b_lat",  32'(lat),  32'd2);
        check("b2b_f",    32'(f),    32'h02);
        check("b2b_cout", 32'(cout), 32'h1);

        // amt=0 in a non-RCL mode clears cout even with cin=1.
        do_op(8'h5A, 2'b01, 3'd0, 1'b1, lat, bcy);
        check("z2_f",    32'(f),    32'h5A);
        check("z2_cout", 32'(cout), 32'h0);

        // Start while busy is ignored: amt=5 LSL of 10110101 -> 10100000, cout=0.
        @(negedge clk);
        x = 8'b10110101; mode = 2'b00; amt = 3'd5; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        x = 8'hFF; mode = 2'b01; amt = 3'd1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_lat",  32'(lat),  32'd6);
        check("ign_f",    32'(f),    32'b10100000);
        check("ign_cout", 32'(cout), 32'h0);

        // Reset in the middle of an operation.
        @(negedge clk);
        x = 8'b10110101; mode = 2'b01; amt = 3'd5; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_f",    32'(f),    32'h00);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_cout", 32'(cout), 32'h0);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        check("mrst_no_done", 32'(lat), 32'd0);

`ifdef SHL_ABORT_EN
        // Abort during SHIFT restores the captured operand, no done.
        @(negedge clk);
        x = 8'b10110101; mode = 2'b10; amt = 3'd5; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_f",    32'(f),    32'b10110101);
        check("ab_cout", 32'(cout), 32'h1);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        check("ab_no_done", 32'(lat), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
